// File: rtl/seq_subtractor_64bit_pkg.sv
// Shared definitions for the sequential adder/subtractor family: FSM state
// encoding and the default datapath geometry used by the adder, subtractor and ALU.
package seq_subtractor_64bit_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_subtractor_64bit_sub_chunk.sv
// Combinational CHUNK-bit subtract with borrow in/out, time-shared across chunks.
// With SEQ_SUB_ADD_MODE_EN defined, op_i selects add (0) or subtract (1).
module seq_subtractor_64bit_sub_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             borrow_i,
`ifdef SEQ_SUB_ADD_MODE_EN
  input  logic             op_i,
`endif
  output logic [CHUNK-1:0] diff_o,
  output logic             borrow_o
);

  logic [CHUNK:0] res;

  // The extra top bit of the widened result is the borrow (or carry) out.
  always_comb begin
`ifdef SEQ_SUB_ADD_MODE_EN
    if (op_i) begin
      res = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, borrow_i};
    end else begin
      res = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, borrow_i};
    end
`else
    res = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, borrow_i};
`endif
  end

  assign diff_o   = res[CHUNK-1:0];
  assign borrow_o = res[CHUNK];

endmodule

// File: rtl/seq_subtractor_64bit.sv
// Multi-cycle A - B, CHUNK bits per clock LSB first, with Y86 condition codes.
// Define SEQ_SUB_ADD_MODE_EN to add the 'op' port (0 = add, 1 = subtract).
module seq_subtractor_64bit
  import seq_subtractor_64bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SEQ_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             borrow,
  output logic             ZF,
  output logic             SF,
  output logic             OF
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;        // shifted right one chunk per RUN edge
  logic             a_msb_q, b_msb_q;
  logic [WIDTH-1:0] work_q, work_d;  // result assembled MSB-side, shifting down
  logic             chain_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, zf_q, sf_q, of_q;
`ifdef SEQ_SUB_ADD_MODE_EN
  logic             op_q;
`endif

  logic [CHUNK-1:0] chunk_diff;
  logic             chunk_borrow;
  logic             last_chunk;
  logic             of_d;

  seq_subtractor_64bit_sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
    .a_i      (a_q[CHUNK-1:0]),
    .b_i      (b_q[CHUNK-1:0]),
    .borrow_i (chain_q),
`ifdef SEQ_SUB_ADD_MODE_EN
    .op_i     (op_q),
`endif
    .diff_o   (chunk_diff),
    .borrow_o (chunk_borrow)
  );

  assign last_chunk = (cnt_q == LAST);
  assign work_d     = (work_q >> CHUNK) | (WIDTH'(chunk_diff) << (WIDTH - CHUNK));

`ifdef SEQ_SUB_ADD_MODE_EN
  assign of_d = op_q ? ((a_msb_q != b_msb_q) && (work_d[WIDTH-1] != a_msb_q))
                     : ((a_msb_q == b_msb_q) && (work_d[WIDTH-1] != a_msb_q));
`else
  assign of_d = (a_msb_q != b_msb_q) && (work_d[WIDTH-1] != a_msb_q);
`endif

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      work_q   <= '0;
      chain_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
`ifdef SEQ_SUB_ADD_MODE_EN
      op_q     <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        a_q     <= A;
        b_q     <= B;
        a_msb_q <= A[WIDTH-1];
        b_msb_q <= B[WIDTH-1];
        cnt_q   <= '0;
        chain_q <= 1'b0;
`ifdef SEQ_SUB_ADD_MODE_EN
        op_q    <= op;
`endif
      end else if (state_q == RUN) begin
        a_q     <= a_q >> CHUNK;
        b_q     <= b_q >> CHUNK;
        work_q  <= work_d;
        chain_q <= chunk_borrow;
        if (last_chunk) begin
          diff_q   <= work_d;
          borrow_q <= chunk_borrow;
          zf_q     <= (work_d == '0);
          sf_q     <= work_d[WIDTH-1];
          of_q     <= of_d;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign Diff   = diff_q;
  assign borrow = borrow_q;
  assign ZF     = zf_q;
  assign SF     = sf_q;
  assign OF     = of_q;

endmodule

// File: tb/tb_seq_subtractor_64bit.sv
// Self-checking bench for seq_subtractor_64bit: directed cases from the test plan
// plus randomized operands against an arithmetic reference model.
module tb_seq_subtractor_64bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] a_in = '0;
  logic [63:0] b_in = '0;
`ifdef SEQ_SUB_ADD_MODE_EN
  logic        op_in = 1'b1;
`endif
  logic        busy, done, borrow, zf, sf, of;
  logic [63:0] diff;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [63:0] d;
    logic        br, zf, sf, of;
  } res_t;

  seq_subtractor_64bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (a_in),
    .B      (b_in),
`ifdef SEQ_SUB_ADD_MODE_EN
    .op     (op_in),
`endif
    .busy   (busy),
    .done   (done),
    .Diff   (diff),
    .borrow (borrow),
    .ZF     (zf),
    .SF     (sf),
    .OF     (of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: exact integer arithmetic; OF means the true signed result
  // does not fit in 64 bits.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input bit add);
    res_t r;
    logic [64:0]        wide;
    logic signed [64:0] s;
    if (add) begin
      wide = {1'b0, a} + {1'b0, b};
      s    = $signed({a[63], a}) + $signed({b[63], b});
      r.br = wide[64];
    end else begin
      wide = {1'b0, a} - {1'b0, b};
      s    = $signed({a[63], a}) - $signed({b[63], b});
      r.br = (a < b);
    end
    r.d  = wide[63:0];
    r.zf = (r.d == 64'd0);
    r.sf = r.d[63];
    r.of = (s[64] != s[63]);
    return r;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit add);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
`ifdef SEQ_SUB_ADD_MODE_EN
    op_in = ~add;
`endif
    @(negedge clk);
    start = 1'b0;
    a_in  = {$urandom, $urandom};
    b_in  = {$urandom, $urandom};
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input bit add);
    res_t e;
    int   cyc;
    e = model(a, b, add);
    issue(a, b, add);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'd4);
    check({tag, ".diff"}, diff, e.d);
    check({tag, ".borrow"}, 64'(borrow), 64'(e.br));
    check({tag, ".zf"}, 64'(zf), 64'(e.zf));
    check({tag, ".sf"}, 64'(sf), 64'(e.sf));
    check({tag, ".of"}, 64'(of), 64'(e.of));
    @(negedge clk);
    check({tag, ".done_drop"}, {62'd0, busy, done}, 64'd0);
    check({tag, ".hold"}, diff, e.d);
  endtask

  initial begin
    int done_cnt;
    logic [63:0] ra, rb;
    bit radd;

    // Reset state
    #12;
    check("rst.outs", {57'd0, busy, done, borrow, zf, sf, of, 1'b0}, 64'd0);
    check("rst.diff", diff, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t_neg45", 64'd2, 64'd47, 1'b0);
    check("t_neg45.const", diff, 64'hFFFF_FFFF_FFFF_FFD3);
    run_op("t_equal", 64'hCCCC_CCCC_CCCC_CCCC, 64'hCCCC_CCCC_CCCC_CCCC, 1'b0);
    run_op("t_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    check("t_ovf.const", diff, 64'h7FFF_FFFF_FFFF_FFFF);

    // Chunk 0 -> 1 borrow, with a start pulse while busy that must be ignored
    issue(64'h0000_0000_0001_0000, 64'd1, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin
        a_in  = 64'd0;
        b_in  = 64'd0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("busy_start.done_cnt", 64'(done_cnt), 64'd1);
    check("busy_start.diff", diff, 64'h0000_0000_0000_FFFF);
    check("busy_start.borrow", 64'(borrow), 64'd0);
    check("busy_start.idle", 64'(busy), 64'd0);

    // Reset during the second RUN cycle
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.outs", {57'd0, busy, done, borrow, zf, sf, of, 1'b0}, 64'd0);
    check("abort.diff", diff, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("abort.no_done", 64'(done_cnt), 64'd0);
    run_op("t_after_rst", 64'd5, 64'd3, 1'b0);
    check("t_after_rst.const", diff, 64'd2);

`ifdef SEQ_SUB_ADD_MODE_EN
    run_op("t_add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    check("t_add_ovf.const", diff, 64'h8000_0000_0000_0000);
`endif

    // Randomized operands, some shaped to stress chunk boundaries and equality
    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case (i % 4)
        1: rb = ra;
        2: begin ra = ra & 64'hFFFF_0000_0000_0000; rb = 64'($urandom_range(1, 3)); end
        3: rb = ra + 64'($urandom_range(0, 2));
        default: ;
      endcase
      radd = 1'b0;
`ifdef SEQ_SUB_ADD_MODE_EN
      radd = 1'($urandom_range(0, 1));
`endif
      run_op($sformatf("rand%0d", i), ra, rb, radd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
